// File: rtl/dds_pkg.sv
// Shared constants for the DDS sample scheduler: Mode limits, segment lengths and FSM encodings.
package dds_pkg;

  localparam int MODE_MIN = 1;
  localparam int MODE_MAX = 5;

  // Segment length N = 10**Mode, kept as a table so no run-time multiply is needed
  localparam int unsigned TC [MODE_MIN:MODE_MAX] = '{10, 100, 1000, 10000, 100000};

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRIME0 = 3'd1;
  localparam logic [2:0] ST_PRIME1 = 3'd2;
  localparam logic [2:0] ST_PRIME2 = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;

  function automatic logic mode_legal(input logic [3:0] mode);
    return (int'(mode) >= MODE_MIN) && (int'(mode) <= MODE_MAX);
  endfunction

  function automatic logic [16:0] term_count(input logic [3:0] mode);
    logic [16:0] tc;
    tc = 17'(TC[MODE_MIN] - 1);
    for (int m = MODE_MIN; m <= MODE_MAX; m++)
      if (int'(mode) == m) tc = 17'(TC[m] - 1);
    return tc;
  endfunction

endpackage

// File: rtl/interp_seg_timer.sv
// Segment timer: counts clocks within a segment, flags the terminal count and owns Mode,
// deferring Mode changes requested while running to the next segment boundary.
module interp_seg_timer import dds_pkg::*; (
  input  logic        Fg_CLK,
  input  logic        RESET,
  input  logic        run_active,
  input  logic        Run,
  input  logic [3:0]  Mode_in,
  input  logic        Mode_load,
  output logic [16:0] cnt,
  output logic        term,
  output logic        boundary,
  output logic [3:0]  Mode,
  output logic        mode_err
);

  logic [3:0] pend_mode;
  logic       pend_vld;
  logic       load_ok;

  assign term     = run_active && (cnt == term_count(Mode));
  assign boundary = term && Run;
  assign load_ok  = Mode_load && mode_legal(Mode_in);

  // NOTE: every register here uses <= so all updates see the pre-edge values of one another.
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      cnt       <= '0;
      Mode      <= 4'(MODE_MIN);
      pend_mode <= 4'(MODE_MIN);
      pend_vld  <= 1'b0;
      mode_err  <= 1'b0;
    end else begin
      mode_err <= Mode_load && !mode_legal(Mode_in);
      cnt      <= (run_active && !term) ? cnt + 17'd1 : '0;

      if (!run_active) begin
        // Outside RUN there is no segment to protect, so requests apply on the next edge
        if (load_ok)       Mode <= Mode_in;
        else if (pend_vld) Mode <= pend_mode;
        pend_vld <= 1'b0;
      end else begin
        if (boundary && pend_vld) Mode <= pend_mode;
        // A load on the boundary cycle itself waits for the following boundary
        if (load_ok) begin
          pend_mode <= Mode_in;
          pend_vld  <= 1'b1;
        end else if (boundary) begin
          pend_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/interp_sequencer.sv
// Sample scheduler for the DDS interpolator: walks the waveform ROM, presents current/next
// samples and pulses Enable at every segment boundary.
module interp_sequencer import dds_pkg::*; #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                     Fg_CLK,
  input  logic                     RESET,
  input  logic                     Run,
  input  logic [ADDR_W-1:0]        Step,
  input  logic [3:0]               Mode_in,
  input  logic                     Mode_load,
  input  logic signed [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0]        rom_addr,
  output logic signed [DATA_W-1:0] out1,
  output logic signed [DATA_W-1:0] out2,
  output logic [3:0]               Mode,
  output logic                     Enable,
  output logic                     Busy,
  output logic                     mode_err
);

  logic [2:0]               state;
  logic [ADDR_W-1:0]        ptr;
  logic [ADDR_W-1:0]        step_q;
  logic [ADDR_W-1:0]        ptr_next;
  logic signed [DATA_W-1:0] prefetch;
  logic [16:0]              cnt;
  logic                     term;
  logic                     boundary;

  assign ptr_next = ptr + step_q;
  assign Busy     = (state != ST_IDLE);

  interp_seg_timer u_timer (
    .Fg_CLK     (Fg_CLK),
    .RESET      (RESET),
    .run_active (state == ST_RUN),
    .Run        (Run),
    .Mode_in    (Mode_in),
    .Mode_load  (Mode_load),
    .cnt        (cnt),
    .term       (term),
    .boundary   (boundary),
    .Mode       (Mode),
    .mode_err   (mode_err)
  );

  // The prefetch address is issued on the Enable edge so its data is valid during cnt==1;
  // this is what forces N>=2.
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      step_q   <= '0;
      prefetch <= '0;
      rom_addr <= '0;
      out1     <= '0;
      out2     <= '0;
      Enable   <= 1'b0;
    end else begin
      Enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Run) begin
            rom_addr <= ptr;
            step_q   <= Step;
            state    <= ST_PRIME0;
          end
        end
        ST_PRIME0: begin
          rom_addr <= ptr_next;
          state    <= ST_PRIME1;
        end
        ST_PRIME1: begin
          prefetch <= rom_data;
          state    <= ST_PRIME2;
        end
        ST_PRIME2: begin
          out2     <= prefetch;
          out1     <= rom_data;
          rom_addr <= ptr + (step_q << 1);
          Enable   <= 1'b1;
          state    <= ST_RUN;
        end
        ST_RUN: begin
          if (cnt == 17'd1) prefetch <= rom_data;
          if (boundary) begin
            ptr      <= ptr_next;
            out2     <= out1;
            out1     <= prefetch;
            step_q   <= Step;
            rom_addr <= ptr_next + (Step << 1);
            Enable   <= 1'b1;
          end else if (term) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interp_sequencer.sv
// Directed bench for interp_sequencer against a synchronous ROM model holding ROM[i] = i*1000.
module tb_interp_sequencer;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic                     Fg_CLK = 1'b0;
  logic                     RESET;
  logic                     Run;
  logic [ADDR_W-1:0]        Step;
  logic [3:0]               Mode_in;
  logic                     Mode_load;
  logic signed [DATA_W-1:0] rom_data = '0;
  logic [ADDR_W-1:0]        rom_addr;
  logic signed [DATA_W-1:0] out1;
  logic signed [DATA_W-1:0] out2;
  logic [3:0]               Mode;
  logic                     Enable;
  logic                     Busy;
  logic                     mode_err;

  int n_cmp  = 0;
  int n_fail = 0;

  interp_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Fg_CLK    (Fg_CLK),
    .RESET     (RESET),
    .Run       (Run),
    .Step      (Step),
    .Mode_in   (Mode_in),
    .Mode_load (Mode_load),
    .rom_data  (rom_data),
    .rom_addr  (rom_addr),
    .out1      (out1),
    .out2      (out2),
    .Mode      (Mode),
    .Enable    (Enable),
    .Busy      (Busy),
    .mode_err  (mode_err)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  // Synchronous ROM: data for an address appears one cycle after the address
  always @(posedge Fg_CLK) rom_data <= DATA_W'(int'(rom_addr) * 1000);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Fg_CLK);
      @(negedge Fg_CLK);
    end
  endtask

  task automatic wait_en(input int limit, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!Enable && n < limit);
  endtask

  task automatic check_seg(input string tag, input int exp_n, input int n,
                           input int exp_o2, input int exp_o1, input int exp_mode);
    check({tag, "_spacing"}, 64'(n), 64'(exp_n));
    check({tag, "_enable"}, 64'(Enable), 64'd1);
    check({tag, "_out2"}, 64'(out2), 64'(exp_o2));
    check({tag, "_out1"}, 64'(out1), 64'(exp_o1));
    check({tag, "_mode"}, 64'(Mode), 64'(exp_mode));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
    check({tag, "_out1"}, 64'(out1), 64'd0);
    check({tag, "_out2"}, 64'(out2), 64'd0);
    check({tag, "_mode"}, 64'(Mode), 64'd1);
    check({tag, "_enable"}, 64'(Enable), 64'd0);
    check({tag, "_busy"}, 64'(Busy), 64'd0);
    check({tag, "_mode_err"}, 64'(mode_err), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int en_seen;

    RESET = 1'b1; Run = 1'b0; Step = 10'd1; Mode_in = 4'd1; Mode_load = 1'b0;
    tick(2);
    RESET = 1'b0;
    check_reset("reset");

    // Priming: first Enable on the 4th edge after Run is sampled
    Run = 1'b1;
    tick(1);
    check("prime0_busy", 64'(Busy), 64'd1);
    check("prime0_addr", 64'(rom_addr), 64'd0);
    tick(1);
    check("prime1_addr", 64'(rom_addr), 64'd1);
    tick(1);
    check("prime2_enable", 64'(Enable), 64'd0);
    tick(1);
    check_seg("first", 4, 4, 0, 1000, 1);
    check("first_prefetch_addr", 64'(rom_addr), 64'd2);
    wait_en(40, n);
    check_seg("second", 10, n, 1000, 2000, 1);
    check("second_prefetch_addr", 64'(rom_addr), 64'd3);

    // Mode 3 requested at cnt=4 takes effect only at the next boundary
    tick(4);
    Mode_in = 4'd3; Mode_load = 1'b1;
    tick(1);
    Mode_load = 1'b0;
    check("mode_pending", 64'(Mode), 64'd1);
    wait_en(40, n);
    check_seg("mode3_apply", 5, n, 2000, 3000, 3);

    // Back to Mode 1, requested at cnt=10 of a 1000-clock segment
    tick(10);
    Mode_in = 4'd1; Mode_load = 1'b1;
    tick(1);
    Mode_load = 1'b0;
    wait_en(1100, n);
    check_seg("mode3_segment", 989, n, 3000, 4000, 1);

    // Illegal Mode requests: single-cycle error, Mode and timing untouched
    tick(2);
    Mode_in = 4'd0; Mode_load = 1'b1;
    tick(1);
    Mode_load = 1'b0;
    check("err0_pulse", 64'(mode_err), 64'd1);
    tick(1);
    check("err0_clear", 64'(mode_err), 64'd0);
    Mode_in = 4'd7; Mode_load = 1'b1;
    tick(1);
    Mode_load = 1'b0;
    check("err7_pulse", 64'(mode_err), 64'd1);
    tick(1);
    check("err7_clear", 64'(mode_err), 64'd0);
    wait_en(40, n);
    check_seg("after_err", 4, n, 4000, 5000, 1);
    wait_en(40, n);
    check_seg("after_err_next", 10, n, 5000, 6000, 1);

    // Run dropped at cnt=3: no Enable, Busy falls at the boundary, samples hold
    tick(3);
    Run = 1'b0;
    tick(6);
    check("stop_busy_before", 64'(Busy), 64'd1);
    check("stop_enable_before", 64'(Enable), 64'd0);
    tick(1);
    check("stop_busy_after", 64'(Busy), 64'd0);
    check("stop_enable_after", 64'(Enable), 64'd0);
    check("stop_out2_hold", 64'(out2), 64'd5000);
    check("stop_out1_hold", 64'(out1), 64'd6000);
    en_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (Enable) en_seen++;
    end
    check("idle_no_enable", 64'(en_seen), 64'd0);

    // Restart re-primes from ptr=5
    Run = 1'b1;
    wait_en(20, n);
    check_seg("reprime", 4, n, 5000, 6000, 1);
    check("reprime_prefetch_addr", 64'(rom_addr), 64'd7);

    // Reset at cnt=5 with Run held: everything returns to reset values, priming from 0
    tick(5);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check_reset("midrun_reset");
    wait_en(20, n);
    check_seg("post_reset", 4, n, 0, 1000, 1);

    // Walk ptr to 1022 with a large Step, then check wrap with Step=1
    tick(2);
    Run = 1'b0;
    tick(8);
    check("walk_idle0", 64'(Busy), 64'd0);
    Step = 10'd1022;
    Run = 1'b1;
    wait_en(20, n);
    check_seg("walk_prime", 4, n, 0, 1022000, 1);
    check("walk_prefetch_addr", 64'(rom_addr), 64'd1020);
    wait_en(40, n);
    check_seg("walk_boundary", 10, n, 1022000, 1020000, 1);
    tick(2);
    Run = 1'b0;
    tick(8);
    check("walk_idle1", 64'(Busy), 64'd0);
    Step = 10'd1;
    Run = 1'b1;
    wait_en(20, n);
    check_seg("wrap_prime", 4, n, 1022000, 1023000, 1);
    check("wrap_prime_addr", 64'(rom_addr), 64'd0);
    wait_en(40, n);
    check_seg("wrap_boundary", 10, n, 1023000, 0, 1);
    check("wrap_prefetch_addr", 64'(rom_addr), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
